// File: rtl/sdram_test_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_test_bridge
//  Purpose  : Buffers tester write/read pulses in a small FIFO and replays them
//             as Avalon-MM transactions with auto-incrementing addresses.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_test_bridge #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int SPAN_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_RD     = 4
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iCLR,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   input  logic              read,
   output logic [DATA_W-1:0] readdata,
   output logic              rd_valid,
   output logic              busy,
   output logic [2:0]        oERR,
   output logic [ADDR_W-1:0] av_address,
   output logic              av_write,
   output logic              av_read,
   output logic [DATA_W-1:0] av_writedata,
   input  logic              av_waitrequest,
   input  logic [DATA_W-1:0] av_readdata,
   input  logic              av_readdatavalid
);

   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_PEND_W = $clog2(MAX_RD + 1);
   localparam logic [c_PEND_W-1:0] c_MAX_RD = c_PEND_W'(MAX_RD);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t              r_state, w_state_nxt;

   // Entry layout: {is_write, data}; read entries carry zero data.
   logic [DATA_W:0]     r_fifo [FIFO_DEPTH];
   logic [c_PTR_W:0]    r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
   logic [SPAN_W-1:0]   r_wr_addr, r_rd_addr, w_wr_addr_nxt, w_rd_addr_nxt;
   logic [c_PEND_W-1:0] r_pend, w_pend_nxt;
   logic [c_PEND_W:0]   w_pend_chk;
   logic [DATA_W:0]     w_head, w_push_word;
   logic                w_empty, w_full;
   logic                w_push, w_push_ok, w_overflow, w_collide, w_spurious;
   logic                w_accept, w_acc_wr, w_acc_rd, w_ret;
   logic                w_issuable, w_load, w_strobe_nxt;

   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                        (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
   assign w_head      = r_fifo[r_rptr[c_PTR_W-1:0]];
   assign w_push      = (write | read) & ~iCLR;
   assign w_push_ok   = w_push & ~w_full;
   assign w_overflow  = w_push & w_full;
   assign w_collide   = write & read & ~iCLR;
   assign w_push_word = write ? {1'b1, writedata} : '0;
   assign w_accept    = (r_state == ST_ISSUE) & ~av_waitrequest;
   assign w_acc_wr    = w_accept & av_write;
   assign w_acc_rd    = w_accept & av_read;
   assign w_ret       = av_readdatavalid & (r_pend != '0);
   assign w_spurious  = av_readdatavalid & (r_pend == '0);

   always_comb begin
      w_wr_addr_nxt = r_wr_addr;
      w_rd_addr_nxt = r_rd_addr;
      if (iCLR) begin
         w_wr_addr_nxt = '0;
         w_rd_addr_nxt = '0;
      end else begin
         if (w_acc_wr) w_wr_addr_nxt = r_wr_addr + SPAN_W'(1);
         if (w_acc_rd) w_rd_addr_nxt = r_rd_addr + SPAN_W'(1);
      end

      w_pend_nxt = r_pend;
      if (w_acc_rd && !w_ret)
         w_pend_nxt = r_pend + c_PEND_W'(1);
      else if (!w_acc_rd && w_ret)
         w_pend_nxt = r_pend - c_PEND_W'(1);

      // A read being accepted this edge already counts against the limit.
      w_pend_chk = {1'b0, r_pend} + {{c_PEND_W{1'b0}}, w_acc_rd};
      w_issuable = !w_empty && !iCLR &&
                   (w_head[DATA_W] || (w_pend_chk < {1'b0, c_MAX_RD}));

      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_issuable) begin
               w_load      = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_accept) begin
               if (w_issuable) w_load      = 1'b1;
               else            w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_strobe_nxt = w_load | ((av_write | av_read) & ~w_accept);

      w_wptr_nxt = r_wptr;
      w_rptr_nxt = r_rptr;
      if (iCLR) begin
         w_wptr_nxt = '0;
         w_rptr_nxt = '0;
      end else begin
         if (w_push_ok) w_wptr_nxt = r_wptr + (c_PTR_W+1)'(1);
         if (w_load)    w_rptr_nxt = r_rptr + (c_PTR_W+1)'(1);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state   <= ST_IDLE;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         r_pend    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_wptr    <= w_wptr_nxt;
         r_rptr    <= w_rptr_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_rd_addr <= w_rd_addr_nxt;
         r_pend    <= w_pend_nxt;
      end
   end

   always_ff @(posedge iCLK) begin
      if (w_push_ok) r_fifo[r_wptr[c_PTR_W-1:0]] <= w_push_word;
   end

   // Loaded addresses use the post-increment counter so back-to-back works.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         av_write     <= 1'b0;
         av_read      <= 1'b0;
         av_address   <= '0;
         av_writedata <= '0;
      end else if (w_load) begin
         av_write     <= w_head[DATA_W];
         av_read      <= ~w_head[DATA_W];
         av_address   <= ADDR_W'(w_head[DATA_W] ? w_wr_addr_nxt : w_rd_addr_nxt);
         av_writedata <= w_head[DATA_W-1:0];
      end else if (w_accept) begin
         av_write     <= 1'b0;
         av_read      <= 1'b0;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         readdata <= '0;
         rd_valid <= 1'b0;
         oERR     <= '0;
         busy     <= 1'b0;
      end else begin
         rd_valid <= w_ret;
         if (w_ret) readdata <= av_readdata;
         if (iCLR) oERR <= '0;
         else      oERR <= oERR | {w_spurious, w_collide, w_overflow};
         busy     <= (w_wptr_nxt != w_rptr_nxt) | w_strobe_nxt | (w_pend_nxt != '0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_test_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_test_bridge
//  Purpose  : Scoreboard bench for sdram_test_bridge with an Avalon slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_test_bridge;

   localparam int ADDR_W     = 25;
   localparam int DATA_W     = 16;
   localparam int SPAN_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int MAX_RD     = 4;
   localparam int SPAN       = 1 << SPAN_W;

   logic              iCLK = 1'b0;
   logic              iRST = 1'b1;
   logic              iCLR = 1'b0;
   logic              write = 1'b0;
   logic              read = 1'b0;
   logic [DATA_W-1:0] writedata = '0;
   logic [DATA_W-1:0] readdata;
   logic              rd_valid;
   logic              busy;
   logic [2:0]        oERR;
   logic [ADDR_W-1:0] av_address;
   logic              av_write;
   logic              av_read;
   logic [DATA_W-1:0] av_writedata;
   logic              av_waitrequest = 1'b0;
   logic [DATA_W-1:0] av_readdata = '0;
   logic              av_readdatavalid = 1'b0;

   always #5 iCLK = ~iCLK;

   sdram_test_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPAN_W(SPAN_W),
      .FIFO_DEPTH(FIFO_DEPTH), .MAX_RD(MAX_RD)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR),
      .write(write), .writedata(writedata), .read(read),
      .readdata(readdata), .rd_valid(rd_valid), .busy(busy), .oERR(oERR),
      .av_address(av_address), .av_write(av_write), .av_read(av_read),
      .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
      .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference model and scoreboard queues
   logic [DATA_W-1:0] tb_mem    [SPAN];
   logic [DATA_W-1:0] slave_mem [SPAN];
   int                tb_wr_addr = 0;
   int                tb_rd_addr = 0;
   int                exp_waq[$];
   logic [DATA_W-1:0] exp_wdq[$];
   int                exp_raq[$];
   logic [DATA_W-1:0] exp_rdq[$];

   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
   } ret_t;
   ret_t ret_q[$];

   int cyc       = 0;
   int ret_lat   = 3;
   int wait_mode = 0;
   int out_cnt   = 0;
   int out_peak  = 0;
   bit spurious  = 1'b0;

   // Slave model: waitrequest pattern and delayed read returns
   always @(posedge iCLK) begin
      cyc++;
      #1;
      case (wait_mode)
         0:       av_waitrequest = 1'b0;
         1:       av_waitrequest = 1'b1;
         default: av_waitrequest = ($urandom_range(3) == 0);
      endcase
      av_readdatavalid = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
         av_readdata      = ret_q[0].data;
         av_readdatavalid = 1'b1;
         void'(ret_q.pop_front());
      end else if (spurious) begin
         av_readdata      = 16'hBEEF;
         av_readdatavalid = 1'b1;
         spurious         = 1'b0;
      end
   end

   always @(negedge iCLK) begin
      if (!iRST) begin
         if (av_readdatavalid && out_cnt > 0) out_cnt--;
         if (av_write && !av_waitrequest) begin
            chk("wr_expected", 32'(exp_waq.size() > 0), 1);
            if (exp_waq.size() > 0) begin
               chk("wr_addr", 32'(av_address), 32'(exp_waq.pop_front()));
               chk("wr_data", 32'(av_writedata), 32'(exp_wdq.pop_front()));
            end
            slave_mem[av_address[SPAN_W-1:0]] = av_writedata;
         end
         if (av_read && !av_waitrequest) begin
            chk("rd_expected", 32'(exp_raq.size() > 0), 1);
            if (exp_raq.size() > 0)
               chk("rd_addr", 32'(av_address), 32'(exp_raq.pop_front()));
            ret_q.push_back('{cyc + 1 + ret_lat, slave_mem[av_address[SPAN_W-1:0]]});
            out_cnt++;
            if (out_cnt > out_peak) out_peak = out_cnt;
            chk("pend_max", 32'(out_cnt <= MAX_RD), 1);
         end
         if (rd_valid) begin
            chk("rdv_expected", 32'(exp_rdq.size() > 0), 1);
            if (exp_rdq.size() > 0)
               chk("rd_data", 32'(readdata), 32'(exp_rdq.pop_front()));
         end
      end
   end

   // One tester cycle; drop=1 means the bridge is expected to discard it.
   task automatic cmd(input logic w, input logic r, input logic [DATA_W-1:0] d, input bit drop);
      @(posedge iCLK);
      #1;
      write     = w;
      read      = r;
      writedata = d;
      if (!drop) begin
         if (w) begin
            exp_waq.push_back(tb_wr_addr);
            exp_wdq.push_back(d);
            tb_mem[tb_wr_addr] = d;
            tb_wr_addr = (tb_wr_addr + 1) % SPAN;
         end else if (r) begin
            exp_raq.push_back(tb_rd_addr);
            exp_rdq.push_back(tb_mem[tb_rd_addr]);
            tb_rd_addr = (tb_rd_addr + 1) % SPAN;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cmd(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic drain(input int max);
      int n = 0;
      idle(1);
      while ((busy !== 1'b0 || exp_waq.size() != 0 || exp_rdq.size() != 0 ||
              exp_raq.size() != 0 || ret_q.size() != 0) && n < max) begin
         @(negedge iCLK);
         n++;
      end
      chk("drain_busy", 32'(busy), 0);
      chk("drain_wq", 32'(exp_waq.size()), 0);
      chk("drain_rq", 32'(exp_rdq.size()), 0);
   endtask

   task automatic do_clr();
      @(posedge iCLK);
      #1 iCLR = 1'b1;
      @(posedge iCLK);
      #1 iCLR = 1'b0;
      tb_wr_addr = 0;
      tb_rd_addr = 0;
      @(negedge iCLK);
      chk("clr_err", 32'(oERR), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] saved;

      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      chk("rst_readdata", 32'(readdata), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(oERR), 0);
      chk("rst_strobes", 32'({av_write, av_read}), 0);
      chk("rst_addr", 32'(av_address), 0);
      chk("rst_wdata", 32'(av_writedata), 0);
      @(posedge iCLK);
      #1 iRST = 1'b0;

      // Pulse-to-strobe latency: strobe visible after the second edge only
      cmd(1'b1, 1'b0, 16'hA5A5, 1'b0);
      cmd(1'b0, 1'b0, '0, 1'b0);
      @(negedge iCLK);
      chk("lat_e0_write", 32'(av_write), 0);
      @(negedge iCLK);
      chk("lat_e1_write", 32'(av_write), 1);
      chk("lat_e1_addr", 32'(av_address), 0);
      chk("lat_e1_data", 32'(av_writedata), 32'h0000A5A5);
      @(negedge iCLK);
      chk("lat_e2_write", 32'(av_write), 0);
      cmd(1'b1, 1'b0, 16'h1234, 1'b0);
      drain(50);

      // Stalled slave: one command in the strobe register, four in the FIFO
      wait_mode = 1;
      for (int i = 0; i < 6; i++) cmd(1'b1, 1'b0, 16'h1000 + 16'(i), i == 5);
      idle(20);
      chk("ovf_err", 32'(oERR), 32'b001);
      wait_mode = 0;
      drain(100);

      // Collision keeps the write, drops the read
      cmd(1'b1, 1'b1, 16'h7777, 1'b0);
      idle(3);
      chk("coll_err", 32'(oERR), 32'b011);
      cmd(1'b0, 1'b1, '0, 1'b0);
      drain(100);

      do_clr();

      // Full span with random stalls; both counters must wrap back to 0
      wait_mode = 2;
      ret_lat   = 3;
      for (int i = 0; i < SPAN; i++) begin
         cmd(1'b1, 1'b0, 16'($urandom), 1'b0);
         idle(2);
      end
      for (int i = 0; i < SPAN; i++) begin
         cmd(1'b0, 1'b1, '0, 1'b0);
         idle(3);
      end
      drain(3000);
      chk("span_err", 32'(oERR), 0);
      cmd(1'b1, 1'b0, 16'h5A5A, 1'b0);
      cmd(1'b0, 1'b1, '0, 1'b0);
      drain(200);

      // Outstanding-read limit with slow returns
      wait_mode = 0;
      ret_lat   = 10;
      out_peak  = 0;
      for (int i = 0; i < 6; i++) cmd(1'b0, 1'b1, '0, 1'b0);
      drain(300);
      chk("pend_peak", 32'(out_peak), 32'(MAX_RD));

      // Unexpected readdatavalid
      ret_lat = 3;
      saved   = readdata;
      @(posedge iCLK);
      #2 spurious = 1'b1;
      idle(4);
      chk("spur_err", 32'(oERR), 32'b100);
      chk("spur_hold", 32'(readdata), 32'(saved));

      do_clr();
      cmd(1'b1, 1'b0, 16'hC3C3, 1'b0);
      cmd(1'b0, 1'b1, '0, 1'b0);
      drain(200);
      chk("final_err", 32'(oERR), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
